// File: rtl/fft_frame_seq.sv
// fft_frame_seq: runs frames through an external streaming FFT core.
// Each frame is loaded, the result is awaited, then read out bin by bin.
module fft_frame_seq #(
  parameter int FFT_SIZE    = 256,
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 65535,
  localparam int AW         = $clog2(FFT_SIZE)
) (
  input  logic             CLK,
  input  logic             NGRST,
  input  logic             ENABLE,
  input  logic             CLR_ERR,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_RE,
  input  logic [WIDTH-1:0] S_IM,
  input  logic             FFT_BUF_READY,
  output logic             FFT_DATAI_VALID,
  output logic [WIDTH-1:0] FFT_DATAI_RE,
  output logic [WIDTH-1:0] FFT_DATAI_IM,
  input  logic             FFT_OUTP_READY,
  output logic             FFT_READ_OUTP,
  input  logic             FFT_DATAO_VALID,
  input  logic [WIDTH-1:0] FFT_DATAO_RE,
  input  logic [WIDTH-1:0] FFT_DATAO_IM,
  output logic             M_VALID,
  output logic [WIDTH-1:0] M_RE,
  output logic [WIDTH-1:0] M_IM,
  output logic [AW-1:0]    M_BIN,
  output logic             M_LAST,
  output logic [15:0]      FRAME_CNT,
  output logic             BUSY,
  output logic             ERR_TIMEOUT,
  output logic             ERR_UNEXP
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_RES,
    READ
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(FFT_SIZE - 1);
  localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT_CYC - 1);

  state_e state_q, state_d;

  logic [AW-1:0]    load_cnt_q, load_cnt_d;
  logic [AW-1:0]    out_cnt_q, out_cnt_d;
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [AW-1:0]    m_bin_q, m_bin_d;
  logic [WIDTH-1:0] m_re_q, m_re_d;
  logic [WIDTH-1:0] m_im_q, m_im_d;
  logic             err_to_q, err_to_d;
  logic             err_ux_q, err_ux_d;

  logic s_ready;
  logic read_outp;
  logic accept;
  logic last_in;
  logic out_fire;
  logic last_out;
  logic to_hit;
  logic ux_set;

  assign accept   = s_ready & S_VALID;
  assign last_in  = load_cnt_q == LAST_IDX;
  assign out_fire = (state_q == READ) & FFT_DATAO_VALID;
  assign last_out = out_cnt_q == LAST_IDX;
  assign ux_set   = (state_q != READ) & FFT_DATAO_VALID;
  assign to_hit   = (state_q == WAIT_RES) & ~FFT_OUTP_READY
                  & (to_cnt_q == TO_LAST);

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ENABLE) state_d = LOAD;
      end
      LOAD: begin
        if (accept && last_in) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (FFT_OUTP_READY) state_d = READ;
        else if (to_hit) state_d = IDLE;
      end
      READ: begin
        if (out_fire && last_out) state_d = ENABLE ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b0;
    read_outp = 1'b0;
    unique case (state_q)
      LOAD:     s_ready   = FFT_BUF_READY;
      WAIT_RES: read_outp = FFT_OUTP_READY;
      default: ;
    endcase
  end

  always_comb begin
    load_cnt_d  = load_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    m_valid_d   = out_fire;
    m_last_d    = out_fire & last_out;
    m_bin_d     = m_bin_q;
    m_re_d      = m_re_q;
    m_im_d      = m_im_q;
    to_cnt_d    = '0;
    if (accept) begin
      load_cnt_d = last_in ? '0 : load_cnt_q + 1'b1;
    end
    if (state_q == WAIT_RES) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
    if (out_fire) begin
      out_cnt_d = last_out ? '0 : out_cnt_q + 1'b1;
      m_bin_d   = out_cnt_q;
      m_re_d    = FFT_DATAO_RE;
      m_im_d    = FFT_DATAO_IM;
      if (last_out) frame_cnt_d = frame_cnt_q + 16'd1;
    end
    // a new error event outranks a simultaneous clear
    err_to_d = to_hit | (err_to_q & ~CLR_ERR);
    err_ux_d = ux_set | (err_ux_q & ~CLR_ERR);
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      load_cnt_q  <= '0;
      out_cnt_q   <= '0;
      to_cnt_q    <= '0;
      frame_cnt_q <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_bin_q     <= '0;
      m_re_q      <= '0;
      m_im_q      <= '0;
      err_to_q    <= 1'b0;
      err_ux_q    <= 1'b0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      out_cnt_q   <= out_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_bin_q     <= m_bin_d;
      m_re_q      <= m_re_d;
      m_im_q      <= m_im_d;
      err_to_q    <= err_to_d;
      err_ux_q    <= err_ux_d;
    end
  end

  assign S_READY         = s_ready;
  assign FFT_DATAI_VALID = accept;
  assign FFT_DATAI_RE    = S_RE;
  assign FFT_DATAI_IM    = S_IM;
  assign FFT_READ_OUTP   = read_outp;
  assign M_VALID         = m_valid_q;
  assign M_LAST          = m_last_q;
  assign M_BIN           = m_bin_q;
  assign M_RE            = m_re_q;
  assign M_IM            = m_im_q;
  assign FRAME_CNT       = frame_cnt_q;
  assign BUSY            = state_q != IDLE;
  assign ERR_TIMEOUT     = err_to_q;
  assign ERR_UNEXP       = err_ux_q;

endmodule

// File: tb/tb_fft_frame_seq.sv
// tb_fft_frame_seq: random frames through a stand-in FFT core, with a
// scoreboard checking every result bin plus error, stall and reset cases.
module tb_fft_frame_seq;

  localparam int N  = 256;
  localparam int W  = 32;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ENABLE, CLR_ERR, S_VALID, S_READY;
  logic [W-1:0] S_RE, S_IM;
  logic         FFT_BUF_READY, FFT_DATAI_VALID;
  logic [W-1:0] FFT_DATAI_RE, FFT_DATAI_IM;
  logic         FFT_OUTP_READY, FFT_READ_OUTP, FFT_DATAO_VALID;
  logic [W-1:0] FFT_DATAO_RE, FFT_DATAO_IM;
  logic         M_VALID, M_LAST, BUSY, ERR_TIMEOUT, ERR_UNEXP;
  logic [W-1:0] M_RE, M_IM;
  logic [7:0]   M_BIN;
  logic [15:0]  FRAME_CNT;

  always #5 clk = ~clk;

  fft_frame_seq #(
    .FFT_SIZE(N), .WIDTH(W), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(clk), .NGRST(rst_n), .ENABLE(ENABLE), .CLR_ERR(CLR_ERR),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_RE(S_RE), .S_IM(S_IM),
    .FFT_BUF_READY(FFT_BUF_READY), .FFT_DATAI_VALID(FFT_DATAI_VALID),
    .FFT_DATAI_RE(FFT_DATAI_RE), .FFT_DATAI_IM(FFT_DATAI_IM),
    .FFT_OUTP_READY(FFT_OUTP_READY), .FFT_READ_OUTP(FFT_READ_OUTP),
    .FFT_DATAO_VALID(FFT_DATAO_VALID), .FFT_DATAO_RE(FFT_DATAO_RE),
    .FFT_DATAO_IM(FFT_DATAO_IM), .M_VALID(M_VALID), .M_RE(M_RE),
    .M_IM(M_IM), .M_BIN(M_BIN), .M_LAST(M_LAST), .FRAME_CNT(FRAME_CNT),
    .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_UNEXP(ERR_UNEXP)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    int           bin;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] core_re[$];
  logic [W-1:0] core_im[$];

  int errors    = 0;
  int checks    = 0;
  int datai_cnt = 0;
  int rd_cnt    = 0;
  int m_cnt     = 0;
  int max_bin   = -1;

  // stand-in core transform: any bijection exposes drops/dups/reorders
  function automatic logic [W-1:0] xf_re(input logic [W-1:0] v);
    return v ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [W-1:0] xf_im(input logic [W-1:0] v);
    return v + 32'd3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (FFT_DATAI_VALID) begin
      datai_cnt++;
      core_re.push_back(FFT_DATAI_RE);
      core_im.push_back(FFT_DATAI_IM);
    end
    if (FFT_READ_OUTP) rd_cnt++;
    if (M_VALID) begin
      m_cnt++;
      if (int'(M_BIN) > max_bin) max_bin = int'(M_BIN);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL m_unexp: M_VALID bin %0d, expected none", M_BIN);
      end else begin
        e = exp_q.pop_front();
        if ({M_RE, M_IM, M_BIN, M_LAST} !==
            {e.re, e.im, 8'(e.bin), e.last}) begin
          errors++;
          $display("FAIL m_bin: got re=%h im=%h bin=%0d last=%b expected re=%h im=%h bin=%0d last=%b",
                   M_RE, M_IM, M_BIN, M_LAST, e.re, e.im, e.bin, e.last);
        end
      end
    end
  end

  task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im);
    int n;
    if ($urandom_range(0, 3) == 0) begin
      S_VALID = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    S_VALID = 1'b1;
    S_RE    = re;
    S_IM    = im;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!S_READY && n < 500);
    if (!S_READY) begin
      checks++;
      errors++;
      $display("FAIL s_ready_wait: got 0 after %0d cycles expected 1", n);
    end
    @(posedge clk);
    #1;
    S_VALID = 1'b0;
  endtask

  task automatic load_frame(input int stall_at, input int drop_at);
    logic [W-1:0] re, im;
    int bad;
    datai_cnt = 0;
    rd_cnt    = 0;
    m_cnt     = 0;
    max_bin   = -1;
    for (int k = 0; k < N; k++) begin
      re = $urandom;
      im = $urandom;
      exp_q.push_back('{re: xf_re(re), im: xf_im(im), bin: k,
                        last: (k == N - 1)});
      if (k == drop_at) ENABLE = 1'b0;
      if (k == stall_at + 1) begin
        bad = 0;
        FFT_BUF_READY = 1'b0;
        S_VALID = 1'b1;
        S_RE = re;
        S_IM = im;
        repeat (5) begin
          @(negedge clk);
          if (S_READY || FFT_DATAI_VALID) bad++;
        end
        chk("stall_sready_low", bad, 0);
        @(posedge clk);
        #1;
        FFT_BUF_READY = 1'b1;
      end
      send_sample(re, im);
    end
  endtask

  task automatic get_result(input int nbins);
    int n;
    repeat (10) @(posedge clk);
    #1;
    FFT_OUTP_READY = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!FFT_READ_OUTP && n < 50);
    chk("read_outp_seen", FFT_READ_OUTP, 1);
    @(posedge clk);
    #1;
    FFT_OUTP_READY = 1'b0;
    for (int k = 0; k < nbins; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      FFT_DATAO_VALID = 1'b1;
      if (core_re.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_empty: got no sample for bin %0d expected one", k);
        FFT_DATAO_RE = '0;
        FFT_DATAO_IM = '0;
      end else begin
        FFT_DATAO_RE = xf_re(core_re.pop_front());
        FFT_DATAO_IM = xf_im(core_im.pop_front());
      end
      @(posedge clk);
      #1;
      FFT_DATAO_VALID = 1'b0;
    end
  endtask

  task automatic end_frame(input int fc);
    repeat (3) @(posedge clk);
    #1;
    chk("m_valid_count", m_cnt, N);
    chk("datai_count", datai_cnt, N);
    chk("read_outp_pulses", rd_cnt, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("frame_cnt", FRAME_CNT, fc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mc;
    rst_n = 1'b0;
    ENABLE = 1'b0;
    CLR_ERR = 1'b0;
    S_VALID = 1'b0;
    S_RE = '0;
    S_IM = '0;
    FFT_BUF_READY = 1'b1;
    FFT_OUTP_READY = 1'b0;
    FFT_DATAO_VALID = 1'b0;
    FFT_DATAO_RE = '0;
    FFT_DATAO_IM = '0;
    #23;
    chk("rst_flags", {S_READY, FFT_DATAI_VALID, FFT_READ_OUTP, M_VALID,
                      M_LAST, BUSY, ERR_TIMEOUT, ERR_UNEXP}, 0);
    chk("rst_data", {M_RE, M_IM}, 0);
    chk("rst_bin_frame", {M_BIN, FRAME_CNT}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    S_VALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", BUSY, 0);
    chk("idle_sready", {S_READY, FFT_DATAI_VALID}, 0);
    S_VALID = 1'b0;

    ENABLE = 1'b1;
    load_frame(-10, -1);
    get_result(N);
    end_frame(1);

    load_frame(100, -1);
    get_result(N);
    end_frame(2);

    load_frame(-10, 50);
    get_result(N);
    end_frame(3);
    chk("drop_idle", BUSY, 0);

    ENABLE = 1'b1;
    @(posedge clk);
    #1;
    chk("load_busy", BUSY, 1);
    mc = m_cnt;
    FFT_DATAO_VALID = 1'b1;
    FFT_DATAO_RE = $urandom;
    FFT_DATAO_IM = $urandom;
    @(posedge clk);
    #1;
    FFT_DATAO_VALID = 1'b0;
    chk("unexp_set", ERR_UNEXP, 1);
    @(posedge clk);
    #1;
    chk("unexp_no_mvalid", m_cnt, mc);
    CLR_ERR = 1'b1;
    @(posedge clk);
    #1;
    CLR_ERR = 1'b0;
    chk("unexp_clear", ERR_UNEXP, 0);
    CLR_ERR = 1'b1;
    FFT_DATAO_VALID = 1'b1;
    @(posedge clk);
    #1;
    CLR_ERR = 1'b0;
    FFT_DATAO_VALID = 1'b0;
    chk("unexp_set_wins", ERR_UNEXP, 1);
    CLR_ERR = 1'b1;
    @(posedge clk);
    #1;
    CLR_ERR = 1'b0;
    chk("unexp_clear2", ERR_UNEXP, 0);

    load_frame(-10, -1);
    ENABLE = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("to_not_yet", {ERR_TIMEOUT, BUSY}, 2'b01);
    @(posedge clk);
    #1;
    chk("to_set_idle", {ERR_TIMEOUT, BUSY}, 2'b10);
    chk("to_frame_cnt", FRAME_CNT, 3);
    chk("to_no_read", rd_cnt, 0);
    exp_q.delete();
    core_re.delete();
    core_im.delete();
    CLR_ERR = 1'b1;
    @(posedge clk);
    #1;
    CLR_ERR = 1'b0;
    chk("to_clear", ERR_TIMEOUT, 0);

    ENABLE = 1'b1;
    load_frame(-10, -1);
    get_result(31);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_flags", {S_READY, FFT_DATAI_VALID, FFT_READ_OUTP, M_VALID,
                          M_LAST, BUSY, ERR_TIMEOUT, ERR_UNEXP}, 0);
    chk("rst_mid_data", {M_RE, M_IM}, 0);
    chk("rst_mid_bin_frame", {M_BIN, FRAME_CNT}, 0);
    chk("rst_mid_max_bin", max_bin, 30);
    FFT_DATAO_VALID = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    FFT_DATAO_VALID = 1'b0;
    chk("rst_mid_no_bin31", m_cnt, 31);
    chk("rst_mid_no_unexp", ERR_UNEXP, 0);
    exp_q.delete();
    core_re.delete();
    core_im.delete();
    rst_n = 1'b1;
    load_frame(-10, -1);
    get_result(N);
    end_frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_seq.md
FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 The block SHALL have parameter FFT_SIZE, default 256, meaning points per frame; legal values are powers of two from 16 to 4096.
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the sample component width matching the FFT core DATAI/DATAO ports.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 65535, meaning the maximum number of cycles it waits for the FFT result.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; all logic SHALL be clocked by CLK and reset by NGRST.
REQ-005 Ports (name  direction  width  meaning):
- CLK  in  1  clock.
- NGRST  in  1  async active-low reset.
- ENABLE  in  1  run frames continuously while high.
- CLR_ERR  in  1  clears sticky error flags.
- S_VALID  in  1  input sample valid.
- S_READY  out  1  sample accepted when S_VALID&S_READY.
- S_RE, S_IM  in  WIDTH  input sample.
- FFT_BUF_READY  in  1  core input buffer ready.
- FFT_DATAI_VALID  out  1  to core DATAI_VALID.
- FFT_DATAI_RE, FFT_DATAI_IM  out  WIDTH  to core.
- FFT_OUTP_READY  in  1  core result available.
- FFT_READ_OUTP  out  1  to core READ_OUTP.
- FFT_DATAO_VALID  in  1  core output valid.
- FFT_DATAO_RE, FFT_DATAO_IM  in  WIDTH  core output.
- M_VALID  out  1  result bin valid; no backpressure.
- M_RE, M_IM  out  WIDTH  result bin.
- M_BIN  out  log2(FFT_SIZE)  bin index.
- M_LAST  out  1  final bin of frame.
- FRAME_CNT  out  16  completed frames, wraps.
- BUSY  out  1  state != IDLE.
- ERR_TIMEOUT, ERR_UNEXP  out  1  sticky errors.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, WAIT_RES and READ.
REQ-007 IDLE -> LOAD when ENABLE=1; in IDLE S_READY=0.
REQ-008 In LOAD: S_READY=FFT_BUF_READY; FFT_DATAI_VALID=S_VALID&S_READY combinationally; FFT_DATAI_RE/IM=S_RE/S_IM pass-through.
REQ-009 In LOAD the load counter SHALL increment per accepted sample. On acceptance of sample FFT_SIZE-1 the counter SHALL clear and the FSM SHALL enter WAIT_RES next cycle.
REQ-010 If FFT_BUF_READY falls mid-frame, acceptance SHALL stall with the count held; no sample SHALL be dropped or duplicated.
REQ-011 In WAIT_RES a timeout counter SHALL run from 0. When FFT_OUTP_READY=1, FFT_READ_OUTP SHALL be driven high for exactly one cycle and the FSM SHALL enter READ.
REQ-012 If the timeout counter reaches TIMEOUT_CYC without FFT_OUTP_READY, ERR_TIMEOUT SHALL set and the FSM SHALL return to IDLE with FRAME_CNT unchanged.
REQ-013 In READ, each FFT_DATAO_VALID SHALL produce M_VALID one cycle later with registered M_RE/M_IM and M_BIN = the output counter value (0..FFT_SIZE-1). M_LAST=1 SHALL accompany bin FFT_SIZE-1.
REQ-014 After output FFT_SIZE-1, FRAME_CNT SHALL increment (wrapping 0xFFFF->0) and the FSM SHALL go to LOAD if ENABLE=1, else to IDLE.
REQ-015 ENABLE falling in LOAD, WAIT_RES or READ SHALL NOT abort the frame; the current frame SHALL complete.
REQ-016 FFT_DATAO_VALID outside READ SHALL set ERR_UNEXP; the data SHALL be discarded (M_VALID stays 0).
REQ-017 CLR_ERR SHALL clear both error flags next cycle. If an error event and CLR_ERR occur in the same cycle, the set SHALL win.
REQ-018 S_READY, FFT_DATAI_VALID and FFT_READ_OUTP SHALL be 0 in every state except where stated in REQ-008 and REQ-011.

Reset
REQ-019 NGRST=0 SHALL asynchronously force: IDLE state; all counters 0; M_VALID, M_LAST, M_BIN, M_RE, M_IM, FRAME_CNT, ERR_TIMEOUT, ERR_UNEXP, BUSY, FFT_READ_OUTP, S_READY, FFT_DATAI_VALID all 0.
REQ-020 Reset asserted mid-frame SHALL discard the partial frame. After release the block SHALL restart from LOAD at count 0 when ENABLE=1.

Verification
REQ-021 The bench SHALL cover a nominal frame: ENABLE=1, BUF_READY=1, 256 samples streamed, OUTP_READY raised 10 cycles later, core emits 256 outputs -> one READ_OUTP pulse, 256 M_VALID with M_BIN 0..255, M_LAST on bin 255, FRAME_CNT=1.
REQ-022 The bench SHALL cover a BUF_READY stall: BUF_READY low for 5 cycles after sample 100 -> S_READY low for those 5 cycles, exactly 256 DATAI_VALID pulses total.
REQ-023 The bench SHALL cover a timeout: TIMEOUT_CYC=100 with OUTP_READY never asserted -> ERR_TIMEOUT=1 at cycle 100 of WAIT_RES, state IDLE, FRAME_CNT=0.
REQ-024 The bench SHALL cover an unexpected output: FFT_DATAO_VALID pulsed in LOAD -> ERR_UNEXP=1, no M_VALID; CLR_ERR pulse -> ERR_UNEXP=0.
REQ-025 The bench SHALL cover ENABLE drop and reset: ENABLE=0 at load sample 50 -> frame completes, FRAME_CNT=1, IDLE. NGRST low in READ at bin 30 -> all outputs 0 immediately, M_VALID never reaches bin 31.
